tcm_dual_port_mem: RTL and testbench

- Tightly-coupled memory (TCM) serving a dual-issue RISC-V core through two ports.
- 64-bit instruction fetch port and 32-bit tagged data port share one 64-bit-wide dual-port RAM.
- Holds program and data for the core; fixed base address 0x8000_0000.
- Includes a simulation backdoor byte-write task used for image preload.

---
 rtl/tcm_dual_port_mem_if.sv | 47 ++++
 rtl/tcm_dual_port_mem.sv | 120 ++++++++++++
 tb/tb_tcm_dual_port_mem.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/tcm_dual_port_mem_if.sv
// Bus bundle between a dual-issue core and its tightly-coupled memory:
// a 64-bit instruction fetch port and a 32-bit tagged data port.
interface tcm_dual_port_mem_if;
    logic        mem_i_rd_i;
    logic        mem_i_flush_i;
    logic        mem_i_invalidate_i;
    logic [31:0] mem_i_pc_i;
    logic        mem_i_accept_o;
    logic        mem_i_valid_o;
    logic        mem_i_error_o;
    logic [63:0] mem_i_inst_o;

    logic [31:0] mem_d_addr_i;
    logic [31:0] mem_d_data_wr_i;
    logic        mem_d_rd_i;
    logic [3:0]  mem_d_wr_i;
    logic        mem_d_cacheable_i;
    logic [10:0] mem_d_req_tag_i;
    logic        mem_d_invalidate_i;
    logic        mem_d_writeback_i;
    logic        mem_d_flush_i;
    logic [31:0] mem_d_data_rd_o;
    logic        mem_d_accept_o;
    logic        mem_d_ack_o;
    logic        mem_d_error_o;
    logic [10:0] mem_d_resp_tag_o;

    modport master (
        output mem_i_rd_i, mem_i_flush_i, mem_i_invalidate_i, mem_i_pc_i,
        input  mem_i_accept_o, mem_i_valid_o, mem_i_error_o, mem_i_inst_o,
        output mem_d_addr_i, mem_d_data_wr_i, mem_d_rd_i, mem_d_wr_i,
        output mem_d_cacheable_i, mem_d_req_tag_i, mem_d_invalidate_i,
        output mem_d_writeback_i, mem_d_flush_i,
        input  mem_d_data_rd_o, mem_d_accept_o, mem_d_ack_o, mem_d_error_o,
        input  mem_d_resp_tag_o
    );

    modport slave (
        input  mem_i_rd_i, mem_i_flush_i, mem_i_invalidate_i, mem_i_pc_i,
        output mem_i_accept_o, mem_i_valid_o, mem_i_error_o, mem_i_inst_o,
        input  mem_d_addr_i, mem_d_data_wr_i, mem_d_rd_i, mem_d_wr_i,
        input  mem_d_cacheable_i, mem_d_req_tag_i, mem_d_invalidate_i,
        input  mem_d_writeback_i, mem_d_flush_i,
        output mem_d_data_rd_o, mem_d_accept_o, mem_d_ack_o, mem_d_error_o,
        output mem_d_resp_tag_o
    );
endinterface

// File: rtl/tcm_dual_port_mem.sv
// Tightly-coupled memory: one 64-bit-wide dual-port RAM shared by a fetch port
// (read-only, 64-bit) and a tagged 32-bit data port with byte write strobes.
module tcm_dual_port_mem_ram #(
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] aAddr_i,
    output logic [63:0]       aRdata_o,
    input  logic [ADDR_W-1:0] bAddr_i,
    input  logic [7:0]        bBe_i,
    input  logic [63:0]       bWdata_i,
    output logic [63:0]       bRdata_o
);
    logic [63:0] ram [0:(1<<ADDR_W)-1];

    // Reads sample the array before this edge's write lands, giving read-first behaviour.
    assign aRdata_o = ram[aAddr_i];
    assign bRdata_o = ram[bAddr_i];

    always @(posedge clk) begin
        for (int k = 0; k < 8; k++) begin
            if (bBe_i[k]) begin
                ram[bAddr_i][8*k +: 8] <= bWdata_i[8*k +: 8];
            end
        end
    end

    task automatic write(input logic [31:0] addr, input logic [7:0] data);
        ram[addr[ADDR_W+2:3]][{addr[2:0], 3'b000} +: 8] <= data;
    endtask
endmodule

module tcm_dual_port_mem #(
    parameter int          MEM_ADDR_W = 14,
    parameter logic [31:0] BASE_ADDR  = 32'h8000_0000
) (
    input logic                 clk,
    input logic                 rst,
    tcm_dual_port_mem_if.slave  bus
);
    logic [MEM_ADDR_W-1:0] fetchIdx;
    logic [MEM_ADDR_W-1:0] dataIdx;
    logic [63:0]           fetchWord;
    logic [63:0]           dataWord;
    logic [7:0]            wrBe;
    logic [63:0]           wrData;
    logic                  dataReq;
    logic                  dataAccess;

    logic        instValid_q, instValid_d;
    logic [63:0] inst_q, inst_d;
    logic        ack_q, ack_d;
    logic [10:0] respTag_q, respTag_d;
    logic [31:0] dataRd_q, dataRd_d;

    assign fetchIdx   = bus.mem_i_pc_i[MEM_ADDR_W+2:3];
    assign dataIdx    = bus.mem_d_addr_i[MEM_ADDR_W+2:3];
    assign wrBe       = bus.mem_d_addr_i[2] ? {bus.mem_d_wr_i, 4'b0000} : {4'b0000, bus.mem_d_wr_i};
    assign wrData     = {bus.mem_d_data_wr_i, bus.mem_d_data_wr_i};
    assign dataAccess = bus.mem_d_rd_i | (|bus.mem_d_wr_i);
    assign dataReq    = dataAccess | bus.mem_d_invalidate_i | bus.mem_d_writeback_i | bus.mem_d_flush_i;

    tcm_dual_port_mem_ram #(.ADDR_W(MEM_ADDR_W)) u_ram (
        .clk      (clk),
        .aAddr_i  (fetchIdx),
        .aRdata_o (fetchWord),
        .bAddr_i  (dataIdx),
        .bBe_i    (wrBe),
        .bWdata_i (wrData),
        .bRdata_o (dataWord)
    );

    always_comb begin
        instValid_d = bus.mem_i_rd_i;
        inst_d      = bus.mem_i_rd_i ? fetchWord : inst_q;
        ack_d       = dataReq;
        respTag_d   = dataReq ? bus.mem_d_req_tag_i : respTag_q;
        dataRd_d    = dataRd_q;
        if (dataAccess) begin
            dataRd_d = bus.mem_d_addr_i[2] ? dataWord[63:32] : dataWord[31:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instValid_q <= 1'b0;
            inst_q      <= '0;
            ack_q       <= 1'b0;
            respTag_q   <= '0;
            dataRd_q    <= '0;
        end else begin
            instValid_q <= instValid_d;
            inst_q      <= inst_d;
            ack_q       <= ack_d;
            respTag_q   <= respTag_d;
            dataRd_q    <= dataRd_d;
        end
    end

    assign bus.mem_i_accept_o   = 1'b1;
    assign bus.mem_i_valid_o    = instValid_q;
    assign bus.mem_i_error_o    = 1'b0;
    assign bus.mem_i_inst_o     = inst_q;
    assign bus.mem_d_accept_o   = 1'b1;
    assign bus.mem_d_ack_o      = ack_q;
    assign bus.mem_d_error_o    = 1'b0;
    assign bus.mem_d_resp_tag_o = respTag_q;
    assign bus.mem_d_data_rd_o  = dataRd_q;

    // Upper address bits are dropped on purpose so accesses alias modulo the memory size.
    logic unusedBits;
    assign unusedBits = ^{bus.mem_i_pc_i[31:MEM_ADDR_W+3], bus.mem_i_pc_i[2:0],
                          bus.mem_d_addr_i[31:MEM_ADDR_W+3], bus.mem_d_addr_i[1:0],
                          bus.mem_i_flush_i, bus.mem_i_invalidate_i,
                          bus.mem_d_cacheable_i, BASE_ADDR};

    task automatic write(input logic [31:0] addr, input logic [7:0] data);
        u_ram.write(addr, data);
    endtask
endmodule

// File: tb/tb_tcm_dual_port_mem.sv
// Scoreboard bench for tcm_dual_port_mem: stimulus pushes expected responses,
// a monitor pops and compares whenever valid or ack is presented.
module tb_tcm_dual_port_mem;
    logic clk;
    logic rst;

    tcm_dual_port_mem_if bus ();

    tcm_dual_port_mem dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] data;
        logic [10:0] tag;
        bit          chk;
    } dataExp_t;

    logic [63:0] fetchQ [$];
    dataExp_t    dataQ  [$];
    int total = 0;
    int bad   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic setInputs(input logic fRd, input logic [31:0] pc, input logic dRd,
                             input logic [3:0] dWr, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [10:0] tag,
                             input logic [2:0] maint);
        bus.mem_i_rd_i         = fRd;
        bus.mem_i_pc_i         = pc;
        bus.mem_i_flush_i      = 1'b0;
        bus.mem_i_invalidate_i = 1'b0;
        bus.mem_d_rd_i         = dRd;
        bus.mem_d_wr_i         = dWr;
        bus.mem_d_addr_i       = addr;
        bus.mem_d_data_wr_i    = wdata;
        bus.mem_d_req_tag_i    = tag;
        bus.mem_d_cacheable_i  = 1'b1;
        bus.mem_d_flush_i      = maint[2];
        bus.mem_d_writeback_i  = maint[1];
        bus.mem_d_invalidate_i = maint[0];
    endtask

    task automatic applyStimulus(input logic fRd, input logic [31:0] pc, input logic dRd,
                                 input logic [3:0] dWr, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [10:0] tag,
                                 input logic [2:0] maint);
        @(posedge clk);
        #1;
        setInputs(fRd, pc, dRd, dWr, addr, wdata, tag, maint);
    endtask

    task automatic applyIdle();
        applyStimulus(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 11'h0, 3'b000);
    endtask

    task automatic expectFetch(input logic [63:0] inst);
        fetchQ.push_back(inst);
    endtask

    task automatic expectData(input logic [31:0] data, input logic [10:0] tag, input bit chk);
        dataExp_t e;
        e.data = data;
        e.tag  = tag;
        e.chk  = chk;
        dataQ.push_back(e);
    endtask

    task automatic waitDrain();
        for (int i = 0; i < 20 && (fetchQ.size() != 0 || dataQ.size() != 0); i++) begin
            @(posedge clk);
            #2;
        end
        checkOutput("drain", 64'(fetchQ.size() + dataQ.size()), 64'd0);
    endtask

    // Monitor: every presented response must match the oldest outstanding expectation.
    initial begin
        dataExp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (bus.mem_i_valid_o) begin
                    if (fetchQ.size() == 0) begin
                        checkOutput("fetch_spurious_valid", 64'(bus.mem_i_valid_o), 64'd0);
                    end else begin
                        checkOutput("fetch_inst", bus.mem_i_inst_o, fetchQ.pop_front());
                    end
                end
                if (bus.mem_d_ack_o) begin
                    if (dataQ.size() == 0) begin
                        checkOutput("data_spurious_ack", 64'(bus.mem_d_ack_o), 64'd0);
                    end else begin
                        e = dataQ.pop_front();
                        checkOutput("data_tag", 64'(bus.mem_d_resp_tag_o), 64'(e.tag));
                        if (e.chk) begin
                            checkOutput("data_rd", 64'(bus.mem_d_data_rd_o), 64'(e.data));
                        end
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        setInputs(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 11'h0, 3'b000);
        rst = 1'b1;
        #3 rst = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        checkOutput("rst_i_valid", 64'(bus.mem_i_valid_o), 64'd0);
        checkOutput("rst_d_ack", 64'(bus.mem_d_ack_o), 64'd0);
        checkOutput("rst_tag", 64'(bus.mem_d_resp_tag_o), 64'd0);
        checkOutput("rst_data", 64'(bus.mem_d_data_rd_o), 64'd0);
        checkOutput("rst_inst", bus.mem_i_inst_o, 64'd0);
        checkOutput("rst_i_accept", 64'(bus.mem_i_accept_o), 64'd1);
        checkOutput("rst_d_accept", 64'(bus.mem_d_accept_o), 64'd1);
        @(posedge clk);
        #1 rst = 1'b1;

        // Backdoor image load and fetch of both words, pc[2:0] ignored.
        for (int i = 0; i < 16; i++) dut.write(32'h8000_0000 + 32'(i), 8'(i));
        expectFetch(64'h0F0E0D0C_0B0A0908);
        applyStimulus(1'b1, 32'h8000_0008, 1'b0, 4'h0, 32'h0, 32'h0, 11'h0, 3'b000);
        expectFetch(64'h07060504_03020100);
        applyStimulus(1'b1, 32'h8000_0000, 1'b0, 4'h0, 32'h0, 32'h0, 11'h0, 3'b000);
        expectFetch(64'h0F0E0D0C_0B0A0908);
        applyStimulus(1'b1, 32'h8000_000C, 1'b0, 4'h0, 32'h0, 32'h0, 11'h0, 3'b000);
        applyIdle();
        waitDrain();

        // Full-word writes into both lanes of word 0, then read back.
        expectData(32'h0, 11'h001, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0, 4'hF, 32'h8000_0000, 32'h0000_2222, 11'h001, 3'b000);
        expectData(32'h0, 11'h002, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0, 4'hF, 32'h8000_0004, 32'h0000_1111, 11'h002, 3'b000);
        expectData(32'h0000_2222, 11'h003, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b1, 4'h0, 32'h8000_0000, 32'h0, 11'h003, 3'b000);
        expectData(32'h0000_1111, 11'h004, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b1, 4'h0, 32'h8000_0004, 32'h0, 11'h004, 3'b000);
        expectData(32'h0000_2222, 11'h005, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b1, 4'h0, 32'h8002_0000, 32'h0, 11'h005, 3'b000);
        applyIdle();
        waitDrain();
        checkOutput("ram0_after_writes", dut.u_ram.ram[0], 64'h00001111_00002222);

        // Partial strobes over a preloaded all-ones word 5.
        for (int i = 8'h28; i < 8'h30; i++) dut.write(32'h8000_0000 + 32'(i), 8'hFF);
        expectData(32'h0, 11'h010, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0, 4'b0011, 32'h8000_0028, 32'hC0DE_000D, 11'h010, 3'b000);
        expectData(32'h0, 11'h011, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0, 4'b1000, 32'h8000_002C, 32'h5A00_0000, 11'h011, 3'b000);
        expectData(32'hFFFF_000D, 11'h012, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b1, 4'h0, 32'h8000_0028, 32'h0, 11'h012, 3'b000);
        expectData(32'h5AFF_FFFF, 11'h013, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b1, 4'h0, 32'h8000_002C, 32'h0, 11'h013, 3'b000);

        // Back-to-back tagged reads.
        expectData(32'h0000_2222, 11'h155, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b1, 4'h0, 32'h8000_0000, 32'h0, 11'h155, 3'b000);
        expectData(32'h0000_1111, 11'h2AA, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b1, 4'h0, 32'h8000_0004, 32'h0, 11'h2AA, 3'b000);
        expectData(32'h0B0A_0908, 11'h7FF, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b1, 4'h0, 32'h8000_0008, 32'h0, 11'h7FF, 3'b000);

        // Read+write same cycle returns old data; maintenance ops leave memory alone.
        expectData(32'h0000_2222, 11'h0C1, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b1, 4'hF, 32'h8000_0000, 32'h3333_3333, 11'h0C1, 3'b000);
        expectData(32'h0, 11'h0AB, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0, 4'h0, 32'h8000_0000, 32'hDEAD_BEEF, 11'h0AB, 3'b100);
        expectData(32'h0, 11'h0AC, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0, 4'h0, 32'h8000_0000, 32'hDEAD_BEEF, 11'h0AC, 3'b010);
        expectData(32'h0, 11'h0AD, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0, 4'h0, 32'h8000_0000, 32'hDEAD_BEEF, 11'h0AD, 3'b001);
        expectData(32'h3333_3333, 11'h0C2, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b1, 4'h0, 32'h8000_0000, 32'h0, 11'h0C2, 3'b000);
        applyIdle();
        waitDrain();

        // Same-cycle fetch and data write to word 3.
        for (int i = 0; i < 8; i++) dut.write(32'h8000_0018 + 32'(i), 8'(8'h88 - 8'(i * 8'h11)));
        expectFetch(64'h11223344_55667788);
        expectData(32'h0, 11'h033, 1'b0);
        applyStimulus(1'b1, 32'h8000_0018, 1'b0, 4'hF, 32'h8000_0018, 32'hAAAA_5555, 11'h033, 3'b000);
        expectFetch(64'h11223344_AAAA5555);
        expectData(32'hAAAA_5555, 11'h034, 1'b1);
        applyStimulus(1'b1, 32'h8000_001C, 1'b1, 4'h0, 32'h8000_0018, 32'h0, 11'h034, 3'b000);
        applyIdle();
        waitDrain();
        checkOutput("inst_hold_valid", 64'(bus.mem_i_valid_o), 64'd0);
        checkOutput("inst_hold_value", bus.mem_i_inst_o, 64'h11223344_AAAA5555);

        // Reset lands while a read and fetch are in flight.
        expectData(32'h0, 11'h044, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0, 4'hF, 32'h8000_0030, 32'h1234_5678, 11'h044, 3'b000);
        expectData(32'h1234_5678, 11'h011, 1'b1);
        expectFetch(64'h0F0E0D0C_0B0A0908);
        applyStimulus(1'b1, 32'h8000_0008, 1'b1, 4'h0, 32'h8000_0030, 32'h0, 11'h011, 3'b000);
        @(posedge clk);
        #2;
        setInputs(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 11'h0, 3'b000);
        rst = 1'b0;
        fetchQ.delete();
        dataQ.delete();
        #1;
        checkOutput("midrst_ack", 64'(bus.mem_d_ack_o), 64'd0);
        checkOutput("midrst_valid", 64'(bus.mem_i_valid_o), 64'd0);
        checkOutput("midrst_tag", 64'(bus.mem_d_resp_tag_o), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        checkOutput("ram0_after_reset", dut.u_ram.ram[0], 64'h00001111_33333333);
        expectData(32'h1234_5678, 11'h055, 1'b1);
        expectFetch(64'h0F0E0D0C_0B0A0908);
        applyStimulus(1'b1, 32'h8000_0008, 1'b1, 4'h0, 32'h8000_0030, 32'h0, 11'h055, 3'b000);
        expectData(32'h0000_1111, 11'h056, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b1, 4'h0, 32'h8000_0004, 32'h0, 11'h056, 3'b000);
        applyIdle();
        waitDrain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
